// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port between NUM_REQ producers.
// Each grant covers one packet (up to `last`), optionally cut short after MAX_BURST beats.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_data_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          burst_cut
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [PW-1:0]        owner_q;
  logic [PW-1:0]        ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 cut_q;

  logic [PW-1:0]        sel_idx;
  logic [DATA_WIDTH-1:0] beat [NUM_REQ];
  logic                 owned;
  logic                 accept;
  logic                 last_beat;
  logic                 limit_hit;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_beat
      assign beat[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Lowest offset from ptr+1 wins: scan offsets downward so the nearest overwrites.
  always_comb begin
    int idx;
    sel_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) sel_idx = PW'(idx);
    end
  end

  assign owned         = (state_q == OWN);
  assign tx_data_valid = owned & req_valid[owner_q];
  assign tx_data       = owned ? beat[owner_q] : '0;
  assign req_ready     = grant_q & {NUM_REQ{tx_data_ready}};
  assign accept        = tx_data_valid & tx_data_ready;
  assign last_beat     = req_last[owner_q];
  assign limit_hit     = (MAX_BURST != 0) && (cnt_q == LIMIT_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      cut_q   <= 1'b0;
    end else begin
      cut_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            state_q <= OWN;
            grant_q <= NUM_REQ'(1) << sel_idx;
            owner_q <= sel_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        OWN: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat || limit_hit) begin
              state_q <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
              ptr_q   <= owner_q;
              cut_q   <= ~last_beat;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign burst_cut = cut_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level round-robin model predicts the beat
// stream; a negedge monitor pops and compares every accepted beat.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int MB = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_last;
  logic [NR-1:0]      req_ready;
  logic               tx_data_valid;
  logic [DW-1:0]      tx_data;
  logic               tx_data_ready;
  logic [NR-1:0]      grant;
  logic               busy;
  logic               burst_cut;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
    .grant(grant), .busy(busy), .burst_cut(burst_cut)
  );

  typedef struct packed {
    logic [7:0]    req;
    logic [DW-1:0] data;
    logic          rel;
    logic          cut;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] bdata [NR][128];
  bit            blast [NR][128];
  int            n   [NR];
  int            pos [NR];
  int            model_ptr = NR - 1;
  int            exp_cuts = 0;
  int            seen_cuts = 0;
  int            ready_mode = 0;
  bit            rand_stall = 0;
  int            stall_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_stim();
    for (int r = 0; r < NR; r++) begin
      n[r]   = 0;
      pos[r] = 0;
    end
  endtask

  task automatic add_pkt(input int r, input int len, input bit rnd, input int base);
    for (int k = 0; k < len; k++) begin
      bdata[r][n[r]] = rnd ? DW'($urandom) : DW'(base + k);
      blast[r][n[r]] = (k == len - 1);
      n[r]++;
    end
  endtask

  // Packet-level reference: rotate from model_ptr+1 over requesters with data left,
  // hand each one a packet chunk of at most MB beats.
  task automatic build_model();
    int   p [NR];
    int   win, cnt;
    bit   found, rel;
    exp_t e;
    for (int r = 0; r < NR; r++) p[r] = pos[r];
    while (1) begin
      found = 0;
      win   = 0;
      for (int k = NR; k >= 1; k--) begin
        if (p[(model_ptr + k) % NR] < n[(model_ptr + k) % NR]) begin
          win   = (model_ptr + k) % NR;
          found = 1;
        end
      end
      if (!found) break;
      cnt = 0;
      rel = 0;
      while (!rel && p[win] < n[win]) begin
        cnt++;
        rel    = blast[win][p[win]] || (MB != 0 && cnt == MB);
        e.req  = 8'(win);
        e.data = bdata[win][p[win]];
        e.rel  = rel;
        e.cut  = rel && !blast[win][p[win]];
        exp_q.push_back(e);
        p[win]++;
      end
      model_ptr = win;
    end
  endtask

  task automatic drive();
    bit has, v;
    for (int i = 0; i < NR; i++) begin
      has = pos[i] < n[i];
      v   = has;
      if (has && grant[i] && rand_stall && $urandom_range(3) == 0) v = 0;
      if (has && i == 0 && grant[0] && stall_left > 0 && pos[0] == 2) begin
        v = 0;
        stall_left--;
      end
      req_valid[i]           = v;
      req_data[i*DW +: DW]   = has ? bdata[i][pos[i]] : DW'($urandom);
      req_last[i]            = has ? blast[i][pos[i]] : 1'b0;
    end
    case (ready_mode)
      0:       tx_data_ready = 1'b1;
      1:       tx_data_ready = ~tx_data_ready;
      default: tx_data_ready = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) pos[i]++;
    drive();
  endtask

  task automatic run_phase(input string name);
    int b = 0;
    while (exp_q.size() > 0 && b < 3000) begin
      tick();
      b++;
    end
    chk({name, "_beats_left"}, exp_q.size(), 0);
    exp_q.delete();
    tick();
    tick();
  endtask

  // Monitor
  bit            in_bubble = 0, prev_bubble = 0, last_cut = 0, prev_hold = 0;
  logic [DW-1:0] prev_data;
  exp_t          mon_e;
  bit            mon_nb;

  always @(negedge clk) begin
    if (rst) begin
      in_bubble   = 0;
      prev_bubble = 0;
      last_cut    = 0;
      prev_hold   = 0;
    end else begin
      chk("busy_vs_grant", busy, |grant);
      chk("grant_onehot", ($countones(grant) <= 1), 1);
      chk("req_ready", req_ready, grant & {NR{tx_data_ready}});
      chk("tx_valid", tx_data_valid, |(req_valid & grant));
      chk("burst_cut", burst_cut, in_bubble && last_cut);
      if (burst_cut) seen_cuts++;
      if (in_bubble) chk("bubble_idle", busy, 0);
      if (prev_bubble && exp_q.size() > 0) chk("regrant_after_bubble", busy, 1);
      if (prev_hold && tx_data_valid) chk("hold_data", tx_data, prev_data);
      mon_nb = 0;
      if (tx_data_valid && tx_data_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %02h grant %0b, required no beat", tx_data, grant);
        end else begin
          mon_e = exp_q.pop_front();
          $display("beat req=%0d data=%02h release=%0d cut=%0d", mon_e.req, tx_data, mon_e.rel, mon_e.cut);
          chk("beat_owner", grant, NR'(1) << mon_e.req);
          chk("beat_data", tx_data, mon_e.data);
          if (mon_e.rel) begin
            mon_nb   = 1;
            last_cut = mon_e.cut;
            if (mon_e.cut) exp_cuts++;
          end
        end
      end
      prev_bubble = in_bubble;
      in_bubble   = mon_nb;
      prev_hold   = tx_data_valid && !tx_data_ready;
      prev_data   = tx_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    tx_data_ready = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    req_last      = '0;
    clear_stim();
    // Round-robin: A0-A2 on req0, B0-B2 on req1, two packets each.
    add_pkt(0, 3, 0, 'hA0);
    add_pkt(1, 3, 0, 'hB0);
    add_pkt(0, 3, 0, 'hA0);
    add_pkt(1, 3, 0, 'hB0);
    build_model();
    drive();
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_valid", tx_data_valid, 0);
    chk("rst_burst_cut", burst_cut, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_grant", grant, 2'b01);
    run_phase("round_robin");

    // Backpressure on a 4-beat packet with ready toggling every cycle.
    clear_stim();
    ready_mode = 1;
    add_pkt(1, 4, 0, 'hC0);
    build_model();
    drive();
    run_phase("backpressure");

    // Burst limit cuts a 6-beat packet, then the 4-beat last/limit coincidence.
    clear_stim();
    ready_mode = 0;
    add_pkt(0, 6, 0, 'h10);
    add_pkt(1, 3, 0, 'h20);
    build_model();
    drive();
    run_phase("burst_cut");
    clear_stim();
    add_pkt(1, 4, 0, 'h30);
    build_model();
    drive();
    run_phase("burst_exact");

    // Owner stalls mid-packet for 10 cycles while req1 waits.
    clear_stim();
    stall_left = 10;
    add_pkt(0, 5, 0, 'h50);
    add_pkt(1, 2, 0, 'h60);
    build_model();
    drive();
    run_phase("owner_stall");
    chk("stall_consumed", stall_left, 0);

    // Randomized traffic with random ready and owner stalls.
    ready_mode = 2;
    rand_stall = 1;
    for (int round = 0; round < 4; round++) begin
      clear_stim();
      for (int r = 0; r < NR; r++) begin
        int np;
        np = $urandom_range(3, 1);
        for (int p = 0; p < np; p++) add_pkt(r, $urandom_range(7, 1), 1, 0);
      end
      build_model();
      drive();
      run_phase("random");
    end

    // Reset in the middle of a 5-beat packet.
    ready_mode = 0;
    rand_stall = 0;
    clear_stim();
    add_pkt(0, 5, 0, 'h70);
    build_model();
    drive();
    begin
      int b = 0;
      while (pos[0] < 2 && b < 200) begin
        tick();
        b++;
      end
      chk("midpkt_progress", pos[0], 2);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tx_valid", tx_data_valid, 0);
    exp_q.delete();
    clear_stim();
    model_ptr = NR - 1;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    add_pkt(1, 2, 0, 'h90);
    add_pkt(0, 2, 0, 'h80);
    build_model();
    drive();
    run_phase("after_reset");

    chk("cut_count", seen_cuts, exp_cuts);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
